// File: rtl/spi_slave_char_fifo.sv
// spi_slave_char_fifo: RX/TX character FIFOs between the SCK-domain slave engine and the bus side.
module spi_slave_char_fifo #(
  parameter int CHAR_NBITS = 32,
  parameter int FIFO_AW    = 2
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  S_ENABLE,
  input  logic                  C_CHAR_DONE,
  input  logic [CHAR_NBITS-1:0] C_RCHAR,
  output logic [CHAR_NBITS-1:0] C_WCHAR,
  input  logic                  RX_RD,
  output logic [CHAR_NBITS-1:0] RX_DATA,
  output logic                  RX_NE,
  output logic [FIFO_AW:0]      RX_CNT,
  input  logic                  TX_WR,
  input  logic [CHAR_NBITS-1:0] TX_DATA,
  output logic                  TX_NF,
  output logic [FIFO_AW:0]      TX_CNT,
  output logic                  RX_OVF,
  output logic                  TX_UNF,
  input  logic                  EVT_CLR
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};
  logic sync0_q, sync0_d, sync1_q, sync1_d, sync2_q, sync2_d;
  logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FIFO_AW:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [CHAR_NBITS-1:0] wchar_q, wchar_d;
  logic tx_valid_q, tx_valid_d, rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;
  logic char_evt, rx_pop, rx_push, tx_push, tx_load;
  logic [CHAR_NBITS-1:0] rx_mem [DEPTH];
  logic [CHAR_NBITS-1:0] tx_mem [DEPTH];
  always_comb begin
    // clearing the chain while disabled drops any done strobe in flight
    sync0_d    = S_ENABLE & C_CHAR_DONE;
    sync1_d    = S_ENABLE & sync0_q;
    sync2_d    = S_ENABLE & sync1_q;
    char_evt   = S_ENABLE & sync1_q & ~sync2_q;
    rx_pop     = S_ENABLE & RX_RD & (rx_cnt_q != '0);
    rx_push    = char_evt & ((rx_cnt_q != FULL) | rx_pop);
    tx_push    = S_ENABLE & TX_WR & (tx_cnt_q != FULL);
    tx_load    = S_ENABLE & (tx_cnt_q != '0) & (char_evt | ~tx_valid_q);
    rx_wp_d    = S_ENABLE ? rx_wp_q + FIFO_AW'(rx_push) : '0;
    rx_rp_d    = S_ENABLE ? rx_rp_q + FIFO_AW'(rx_pop) : '0;
    rx_cnt_d   = S_ENABLE ? rx_cnt_q + (FIFO_AW+1)'(rx_push) - (FIFO_AW+1)'(rx_pop) : '0;
    tx_wp_d    = S_ENABLE ? tx_wp_q + FIFO_AW'(tx_push) : '0;
    tx_rp_d    = S_ENABLE ? tx_rp_q + FIFO_AW'(tx_load) : '0;
    tx_cnt_d   = S_ENABLE ? tx_cnt_q + (FIFO_AW+1)'(tx_push) - (FIFO_AW+1)'(tx_load) : '0;
    wchar_d    = !S_ENABLE ? '1 : tx_load ? tx_mem[tx_rp_q] : char_evt ? '1 : wchar_q;
    tx_valid_d = S_ENABLE & (tx_load | (tx_valid_q & ~char_evt));
    rx_ovf_d   = (char_evt & ~rx_push) | (rx_ovf_q & ~EVT_CLR);
    tx_unf_d   = (char_evt & ~tx_valid_q) | (tx_unf_q & ~EVT_CLR);
  end
  always_ff @(posedge S_SYSCLK or negedge S_RESETN)
    if (!S_RESETN) begin
      sync0_q    <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      wchar_q    <= '1;
      tx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_unf_q   <= 1'b0;
    end else begin
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      wchar_q    <= wchar_d;
      tx_valid_q <= tx_valid_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_unf_q   <= tx_unf_d;
    end
  // storage needs no reset: occupancy gates every read
  always_ff @(posedge S_SYSCLK) begin
    if (rx_push) rx_mem[rx_wp_q] <= C_RCHAR;
    if (tx_push) tx_mem[tx_wp_q] <= TX_DATA;
  end
  assign C_WCHAR = wchar_q;
  assign RX_NE   = rx_cnt_q != '0;
  assign RX_DATA = RX_NE ? rx_mem[rx_rp_q] : '1;
  assign RX_CNT  = rx_cnt_q;
  assign TX_NF   = tx_cnt_q != FULL;
  assign TX_CNT  = tx_cnt_q;
  assign RX_OVF  = rx_ovf_q;
  assign TX_UNF  = tx_unf_q;
endmodule

// File: tb/tb_spi_slave_char_fifo.sv
// tb_spi_slave_char_fifo: scoreboard bench for the SPI slave character FIFOs.
module tb_spi_slave_char_fifo;
  logic clk = 0, rst_n = 0, en = 0, done = 0, rx_rd = 0, tx_wr = 0, evt_clr = 0;
  logic [31:0] rchar = '0, tx_data = '0;
  logic [31:0] wchar, rx_data;
  logic rx_ne, tx_nf, rx_ovf, tx_unf;
  logic [2:0] rx_cnt, tx_cnt;
  logic [31:0] rxq [$];
  logic exp_ovf = 0;
  int vecs = 0, errs = 0;
  spi_slave_char_fifo dut (
    .S_SYSCLK(clk), .S_RESETN(rst_n), .S_ENABLE(en), .C_CHAR_DONE(done), .C_RCHAR(rchar),
    .C_WCHAR(wchar), .RX_RD(rx_rd), .RX_DATA(rx_data), .RX_NE(rx_ne), .RX_CNT(rx_cnt),
    .TX_WR(tx_wr), .TX_DATA(tx_data), .TX_NF(tx_nf), .TX_CNT(tx_cnt),
    .RX_OVF(rx_ovf), .TX_UNF(tx_unf), .EVT_CLR(evt_clr)
  );
  always #5 clk = ~clk;
  task automatic done_pulse(input logic [31:0] v, input logic rd, input logic wr, input logic clr, input logic [31:0] td);
    @(posedge clk); #1; rchar = v; done = 1;
    @(posedge clk); @(posedge clk); #1;
    done = 0; rx_rd = rd; tx_wr = wr; tx_data = td; evt_clr = clr;
    if (rd && rxq.size() > 0) begin
      vecs++; if (rx_data !== rxq[0]) begin errs++; $display("FAIL evt_rd_data got %h want %h", rx_data, rxq[0]); end
      void'(rxq.pop_front());
    end
    if (rxq.size() < 4) begin rxq.push_back(v); if (clr) exp_ovf = 0; end
    else exp_ovf = 1;
    @(posedge clk); #1; rx_rd = 0; tx_wr = 0; evt_clr = 0;
    vecs++; if (rx_ovf !== exp_ovf) begin errs++; $display("FAIL evt_ovf got %b want %b", rx_ovf, exp_ovf); end
    vecs++; if (rx_cnt !== 3'(rxq.size())) begin errs++; $display("FAIL evt_rx_cnt got %0d want %0d", rx_cnt, rxq.size()); end
  endtask
  task automatic rx_read();
    vecs++; if (rx_data !== rxq[0]) begin errs++; $display("FAIL rd_data got %h want %h", rx_data, rxq[0]); end
    void'(rxq.pop_front());
    rx_rd = 1; @(posedge clk); #1; rx_rd = 0;
    vecs++; if (rx_cnt !== 3'(rxq.size())) begin errs++; $display("FAIL rd_cnt got %0d want %0d", rx_cnt, rxq.size()); end
  endtask
  task automatic tx_write(input logic [31:0] d);
    tx_wr = 1; tx_data = d; @(posedge clk); #1; tx_wr = 0;
  endtask
  task automatic clr_flags();
    evt_clr = 1; @(posedge clk); #1; evt_clr = 0; exp_ovf = 0;
  endtask
  task automatic test_reset();
    #12;
    vecs++; if ({rx_cnt, tx_cnt, rx_ne, tx_nf, rx_ovf, tx_unf} !== 10'b0000000100) begin errs++; $display("FAIL reset_status got %b want 0000000100", {rx_cnt, tx_cnt, rx_ne, tx_nf, rx_ovf, tx_unf}); end
    vecs++; if (wchar !== '1) begin errs++; $display("FAIL reset_wchar got %h want ffffffff", wchar); end
    vecs++; if (rx_data !== '1) begin errs++; $display("FAIL reset_rx_data got %h want ffffffff", rx_data); end
    @(posedge clk); #1; rst_n = 1; en = 1;
  endtask
  task automatic test_preload();
    tx_write(32'hA5A5A5A5); tx_write(32'h5A5A5A5A);
    vecs++; if (wchar !== 32'hA5A5A5A5) begin errs++; $display("FAIL preload_wchar got %h want a5a5a5a5", wchar); end
    vecs++; if (tx_cnt !== 3'd1) begin errs++; $display("FAIL preload_cnt got %0d want 1", tx_cnt); end
    done_pulse(32'hC1, 0, 0, 0, 0);
    vecs++; if ({wchar, tx_cnt, tx_unf} !== {32'h5A5A5A5A, 3'd0, 1'b0}) begin errs++; $display("FAIL unf_done1 got %h/%0d/%b want 5a5a5a5a/0/0", wchar, tx_cnt, tx_unf); end
    done_pulse(32'hC2, 0, 0, 0, 0);
    vecs++; if ({wchar, tx_unf} !== {32'hFFFFFFFF, 1'b0}) begin errs++; $display("FAIL unf_done2 got %h/%b want ffffffff/0", wchar, tx_unf); end
    done_pulse(32'hC3, 0, 0, 0, 0);
    vecs++; if ({wchar, tx_unf} !== {32'hFFFFFFFF, 1'b1}) begin errs++; $display("FAIL unf_done3 got %h/%b want ffffffff/1", wchar, tx_unf); end
    clr_flags();
    vecs++; if (tx_unf !== 1'b0) begin errs++; $display("FAIL unf_clear got %b want 0", tx_unf); end
    while (rxq.size() > 0) rx_read();
  endtask
  task automatic test_rx_wrap();
    for (int i = 1; i <= 6; i++) begin
      done_pulse(32'(i), 0, 0, 0, 0);
      vecs++; if (rx_cnt !== 3'd1) begin errs++; $display("FAIL wrap_cnt got %0d want 1", rx_cnt); end
      rx_read();
    end
  endtask
  task automatic test_overflow();
    clr_flags();
    for (int i = 0; i < 5; i++) begin
      vecs++; if (rx_ovf !== 1'b0) begin errs++; $display("FAIL ovf_early got %b want 0", rx_ovf); end
      done_pulse(32'h10 + 32'(i), 0, 0, 0, 0);
    end
    vecs++; if ({rx_cnt, rx_ovf} !== {3'd4, 1'b1}) begin errs++; $display("FAIL ovf_full got %0d/%b want 4/1", rx_cnt, rx_ovf); end
    for (int i = 0; i < 4; i++) rx_read();
    clr_flags();
    vecs++; if (rx_ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", rx_ovf); end
  endtask
  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) done_pulse(32'h20 + 32'(i), 0, 0, 0, 0);
    clr_flags();
    done_pulse(32'h24, 1, 0, 0, 0);
    vecs++; if ({rx_cnt, rx_ovf} !== {3'd4, 1'b0}) begin errs++; $display("FAIL rd_evt got %0d/%b want 4/0", rx_cnt, rx_ovf); end
    tx_write(32'hB0); tx_write(32'hB1); tx_write(32'hB2);
    vecs++; if ({wchar, tx_cnt} !== {32'hB0, 3'd2}) begin errs++; $display("FAIL tx_fill got %h/%0d want b0/2", wchar, tx_cnt); end
    done_pulse(32'h25, 1, 1, 0, 32'hB3);
    vecs++; if ({wchar, tx_cnt} !== {32'hB1, 3'd2}) begin errs++; $display("FAIL wr_evt got %h/%0d want b1/2", wchar, tx_cnt); end
    done_pulse(32'h26, 0, 0, 1, 0);
    vecs++; if (rx_ovf !== 1'b1) begin errs++; $display("FAIL clr_vs_set got %b want 1", rx_ovf); end
    vecs++; if (wchar !== 32'hB2) begin errs++; $display("FAIL wr_evt_next got %h want b2", wchar); end
  endtask
  task automatic test_sync_latency();
    while (rxq.size() > 0) rx_read();
    @(posedge clk); #1; rchar = 32'h77; done = 1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      vecs++; if (rx_ne !== (e == 3)) begin errs++; $display("FAIL sync_edge%0d got %b want %b", e, rx_ne, e == 3); end
    end
    rxq.push_back(32'h77);
    repeat (7) @(posedge clk);
    #1; done = 0;
    repeat (5) @(posedge clk);
    #1;
    vecs++; if (rx_cnt !== 3'd1) begin errs++; $display("FAIL sync_single got %0d want 1", rx_cnt); end
    rx_read();
  endtask
  task automatic test_flush();
    clr_flags();
    done_pulse(32'h88, 0, 0, 0, 0);
    done_pulse(32'h89, 0, 0, 0, 0);
    tx_write(32'hC0); tx_write(32'hC1); tx_write(32'hC2);
    vecs++; if ({wchar, tx_cnt, rx_cnt} !== {32'hC0, 3'd2, 3'd2}) begin errs++; $display("FAIL flush_pre got %h/%0d/%0d want c0/2/2", wchar, tx_cnt, rx_cnt); end
    en = 0; @(posedge clk); #1; en = 1;
    rxq.delete();
    vecs++; if ({rx_cnt, tx_cnt, rx_ne, rx_ovf, tx_unf} !== {3'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin errs++; $display("FAIL flush_state got %b want 000000001", {rx_cnt, tx_cnt, rx_ne, rx_ovf, tx_unf}); end
    vecs++; if ({wchar, rx_data} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin errs++; $display("FAIL flush_data got %h/%h want all ones", wchar, rx_data); end
  endtask
  task automatic test_async_reset();
    tx_write(32'hE0); tx_write(32'hE1);
    done_pulse(32'h99, 0, 0, 0, 0);
    @(posedge clk); #3; rst_n = 0; #1;
    vecs++; if ({rx_cnt, tx_cnt, rx_ne, tx_nf, rx_ovf, tx_unf} !== 10'b0000000100) begin errs++; $display("FAIL areset_status got %b want 0000000100", {rx_cnt, tx_cnt, rx_ne, tx_nf, rx_ovf, tx_unf}); end
    vecs++; if ({wchar, rx_data} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin errs++; $display("FAIL areset_data got %h/%h want all ones", wchar, rx_data); end
    rxq.delete(); exp_ovf = 0;
    @(posedge clk); #1; rst_n = 1;
  endtask
  task automatic test_tx_full();
    for (int i = 0; i < 6; i++) tx_write(32'hD0 + 32'(i));
    vecs++; if ({wchar, tx_cnt, tx_nf} !== {32'hD0, 3'd4, 1'b0}) begin errs++; $display("FAIL tx_full got %h/%0d/%b want d0/4/0", wchar, tx_cnt, tx_nf); end
    for (int i = 1; i <= 5; i++) begin
      done_pulse(32'h40 + 32'(i), 0, 0, 0, 0);
      vecs++; if (wchar !== (i == 5 ? 32'hFFFFFFFF : 32'hD0 + 32'(i))) begin errs++; $display("FAIL tx_drain%0d got %h want %h", i, wchar, i == 5 ? 32'hFFFFFFFF : 32'hD0 + 32'(i)); end
    end
  endtask
  initial begin
    test_reset();
    test_preload();
    test_rx_wrap();
    test_overflow();
    test_simultaneous();
    test_sync_latency();
    test_flush();
    test_async_reset();
    test_tx_full();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
